// File: rtl/ps2_defs.sv
// Shared PS/2 receive definitions: FSM encoding, frame geometry and parity sense.
package ps2_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;
  // Frame minus start, parity and stop leaves the data-bit index range.
  localparam int IDX_W      = $clog2(FRAME_BITS - 3);
  localparam logic PARITY_ODD = 1'b1;

  function automatic logic frame_ok(input logic [DATA_BITS-1:0] data,
                                    input logic parity,
                                    input logic stop);
    return stop && ((^data ^ parity) == PARITY_ODD);
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO with occupancy counter; head is read straight from the storage registers.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO only fits if the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync, glitch filter, frame FSM with timeout, scancode FIFO.
// Optional macro PS2_INHIBIT_EN drives clk_inhibit while the FIFO is full between frames.
module ps2_rx
  import ps2_defs::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk_core,
  input  logic       core_reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_flags,
  output logic       clk_inhibit
);

  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  logic                 r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic                 r_filt_clk;
  logic [FW-1:0]        r_filt_cnt;
  logic                 r_bit_evt;
  logic                 r_data_smp;
  ps2_state_e           r_state;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [TW-1:0]        r_tmo_cnt;
  logic                 r_frame_err;
  logic                 r_push;
  logic                 r_overflow;
  logic                 w_full, w_empty, w_pop, w_drop;
  logic [CW-1:0]        w_count;

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= ps2_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Filtered clock follows the pad only after FILTER_CYCLES stable cycles; a falling
  // transition latches data and raises a one-cycle bit event.
  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
      r_bit_evt  <= 1'b0;
      r_data_smp <= 1'b1;
    end else begin
      r_bit_evt <= 1'b0;
      if (r_clk_sync != r_filt_clk) begin
        if (r_filt_cnt == FILT_MAX) begin
          r_filt_clk <= r_clk_sync;
          r_filt_cnt <= '0;
          if (r_filt_clk) begin
            r_bit_evt  <= 1'b1;
            r_data_smp <= r_dat_sync;
          end
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      r_state     <= ST_IDLE;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tmo_cnt   <= '0;
      r_frame_err <= 1'b0;
      r_push      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_push      <= 1'b0;
      if (r_bit_evt) begin
        r_tmo_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!r_data_smp) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end
          end
          ST_DATA: begin
            r_shift <= {r_data_smp, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == IDX_W'(DATA_BITS - 1)) r_state <= ST_PARITY;
            else r_bit_idx <= r_bit_idx + 1'b1;
          end
          ST_PARITY: begin
            r_parity <= r_data_smp;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            if (frame_ok(r_shift, r_parity, r_data_smp)) r_push <= 1'b1;
            else r_frame_err <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state == ST_IDLE) begin
        r_tmo_cnt <= '0;
      end else if (r_tmo_cnt == TMO_MAX) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
        r_tmo_cnt   <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign w_pop  = rd_ready & ~w_empty;
  assign w_drop = r_push & w_full & ~w_pop;

  // r_shift holds the completed byte until the next frame's data bits arrive.
  ps2_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk_core),
    .i_rst_n     (core_reset_n),
    .i_push      (r_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_head      (rd_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
    else if (clr_flags) r_overflow <= 1'b0;
  end

  assign rd_valid  = (w_count != '0);
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

`ifdef PS2_INHIBIT_EN
  logic r_inhibit;
  // Raised only between frames; held while full so a started frame is never cut.
  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) r_inhibit <= 1'b0;
    else r_inhibit <= w_full & (r_inhibit | (r_state == ST_IDLE));
  end
  assign clk_inhibit = r_inhibit;
`else
  assign clk_inhibit = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: frame driver, scoreboard queue on the read port, summary report.
module tb_ps2_rx;

  localparam int FILTER_CYCLES  = 8;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int FIFO_DEPTH     = 4;
`ifdef PS2_INHIBIT_EN
  localparam logic INH = 1'b1;
`else
  localparam logic INH = 1'b0;
`endif

  logic       clk_core     = 1'b0;
  logic       core_reset_n = 1'b0;
  logic       ps2_clk      = 1'b1;
  logic       ps2_data     = 1'b1;
  logic       rd_ready     = 1'b0;
  logic       clr_flags    = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overflow;
  logic       clk_inhibit;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int e0       = 0;
  logic [7:0] exp_q[$];

  ps2_rx #(
    .FILTER_CYCLES  (FILTER_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk_core     (clk_core),
    .core_reset_n (core_reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clr_flags    (clr_flags),
    .clk_inhibit  (clk_inhibit)
  );

  // Clock and watchdog
  always #5 clk_core = ~clk_core;

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare each consumed byte against the oldest expected one.
  always @(negedge clk_core) begin
    #1;
    if (core_reset_n) begin
      if (frame_err) err_cnt++;
      if (rd_valid && rd_ready)
        check("sb_pop", 32'(rd_data), (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD);
    end
  end

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_core);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    cyc(FILTER_CYCLES - 2);
    ps2_clk = 1'b1;
    cyc(20);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input int n_bits, input int glitch_at);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < n_bits; i++) begin
      if (i == glitch_at) glitch();
      ps2_data = bits[i];
      cyc(20);
      ps2_clk = 1'b0;
      cyc(40);
      ps2_clk = 1'b1;
      cyc(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      cyc(1);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    cyc(3);
    #1;
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_inh", 32'(clk_inhibit), 32'd0);
    @(negedge clk_core);
    core_reset_n = 1'b1;
    cyc(5);

    // Clean frame 0x1C
    rd_ready = 1'b1;
    e0 = err_cnt;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
    wait_drain("t1_drain");
    check("t1_err", 32'(err_cnt - e0), 32'd0);

    // Bad parity, then bad stop
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
    cyc(10);
    check("t2_par_err", 32'(err_cnt - e0), 32'd1);
    check("t2_par_valid", 32'(rd_valid), 32'd0);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    cyc(10);
    check("t2_stop_err", 32'(err_cnt - e0), 32'd1);
    check("t2_stop_valid", 32'(rd_valid), 32'd0);

    // Clock glitches in IDLE and mid-DATA
    e0 = err_cnt;
    glitch();
    exp_q.push_back(8'hA7);
    send_frame(8'hA7, 1'b0, 1'b0, 11, 4);
    wait_drain("t3_drain");
    check("t3_err", 32'(err_cnt - e0), 32'd0);

    // Stall after four data bits
    e0 = err_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 5, -1);
    cyc(TIMEOUT_CYCLES - 200);
    check("t4_early", 32'(err_cnt - e0), 32'd0);
    cyc(300);
    check("t4_tmo", 32'(err_cnt - e0), 32'd1);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
    wait_drain("t4_drain");
    check("t4_err_after", 32'(err_cnt - e0), 32'd1);

    // FIFO fill and overflow with no consumer
    rd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= FIFO_DEPTH) exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b0, 1'b0, 11, -1);
      cyc(5);
      if (k == FIFO_DEPTH) begin
        check("t5_ovf_full", 32'(overflow), 32'd0);
        check("t5_inh_full", 32'(clk_inhibit), 32'(INH));
      end
    end
    check("t5_ovf", 32'(overflow), 32'd1);
    check("t5_valid", 32'(rd_valid), 32'd1);
    check("t5_head", 32'(rd_data), 32'h01);
    check("t5_inh_hold", 32'(clk_inhibit), 32'(INH));
    @(negedge clk_core);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    #1;
    check("t5_clr", 32'(overflow), 32'd0);
    @(negedge clk_core);
    rd_ready = 1'b1;
    @(negedge clk_core);
    #1;
    check("t5_inh_pop", 32'(clk_inhibit), 32'(INH));
    @(negedge clk_core);
    #1;
    check("t5_inh_rel", 32'(clk_inhibit), 32'd0);
    wait_drain("t5_drain");

    // Reset in the middle of a frame
    rd_ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b0, 11, -1);
    cyc(5);
    check("t6_pre_valid", 32'(rd_valid), 32'd1);
    check("t6_pre_data", 32'(rd_data), 32'h33);
    send_frame(8'h55, 1'b0, 1'b0, 4, -1);
    @(negedge clk_core);
    core_reset_n = 1'b0;
    #1;
    check("t6_valid", 32'(rd_valid), 32'd0);
    check("t6_data", 32'(rd_data), 32'd0);
    check("t6_err", 32'(frame_err), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_inh", 32'(clk_inhibit), 32'd0);
    cyc(3);
    core_reset_n = 1'b1;
    cyc(3);
    rd_ready = 1'b1;
    e0 = err_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 11, -1);
    wait_drain("t6_drain");
    check("t6_err_after", 32'(err_cnt - e0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
